// File: rtl/header_sequencer.sv
// header_sequencer: frame-level controller for the Ethernet header parser.
// Arms the parser, follows its four field-valid pulses in order under
// per-phase watchdogs, times the payload window and the inter-frame gap,
// and reports completion/error with saturating frame and error counters.
module header_sequencer #(
   parameter int HUNT_TIMEOUT  = 64,
   parameter int FIELD_TIMEOUT = 16,
   parameter int PAYLOAD_LEN   = 46,
   parameter int IFG_CYCLES    = 12,
   parameter int CNT_W         = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             ctrl_enable,
   input  logic             rx_active,
   input  logic             preamble_valid,
   input  logic             dst_addr_valid,
   input  logic             src_addr_valid,
   input  logic             type_length_valid,
   output logic             parser_enable,
   output logic             payload_active,
   output logic [7:0]       payload_index,
   output logic             frame_done,
   output logic             frame_error,
   output logic [2:0]       error_code,
   output logic [CNT_W-1:0] frame_count,
   output logic [CNT_W-1:0] error_count
);

   // One shared watchdog serves every phase, so it is sized for the longest.
   localparam int MAX_HF = (HUNT_TIMEOUT > FIELD_TIMEOUT) ? HUNT_TIMEOUT : FIELD_TIMEOUT;
   localparam int MAX_PG = (PAYLOAD_LEN > IFG_CYCLES) ? PAYLOAD_LEN : IFG_CYCLES;
   localparam int WD_MAX = (MAX_HF > MAX_PG) ? MAX_HF : MAX_PG;
   localparam int WD_W   = $clog2(WD_MAX + 1);

   localparam logic [WD_W-1:0] HUNT_LAST  = WD_W'(HUNT_TIMEOUT - 1);
   localparam logic [WD_W-1:0] FIELD_LAST = WD_W'(FIELD_TIMEOUT - 1);
   localparam logic [WD_W-1:0] PAY_LAST   = WD_W'(PAYLOAD_LEN - 1);
   localparam logic [WD_W-1:0] IFG_LAST   = WD_W'(IFG_CYCLES - 1);

   localparam logic [2:0] ERR_NONE      = 3'd0;
   localparam logic [2:0] ERR_NO_SOF    = 3'd1;
   localparam logic [2:0] ERR_FIELD_TMO = 3'd2;
   localparam logic [2:0] ERR_SEQUENCE  = 3'd3;
   localparam logic [2:0] ERR_TRUNCATED = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HUNT,
      S_DST,
      S_SRC,
      S_TYPE,
      S_PAYLOAD,
      S_GAP
   } state_t;

   state_t          state, state_nxt;
   logic [WD_W-1:0] wdog, wdog_nxt;
   logic            err_fire;
   logic [2:0]      err_sel;
   logic            done_fire;
   logic            exp_v;
   logic            other_v;
   state_t          field_adv;

   // Expected valid for the current header field, everything else is a
   // sequence violation (a repeated preamble included).
   always_comb begin
      exp_v     = 1'b0;
      other_v   = 1'b0;
      field_adv = S_GAP;
      case (state)
         S_DST: begin
            exp_v     = dst_addr_valid;
            other_v   = preamble_valid | src_addr_valid | type_length_valid;
            field_adv = S_SRC;
         end
         S_SRC: begin
            exp_v     = src_addr_valid;
            other_v   = preamble_valid | dst_addr_valid | type_length_valid;
            field_adv = S_TYPE;
         end
         S_TYPE: begin
            exp_v     = type_length_valid;
            other_v   = preamble_valid | dst_addr_valid | src_addr_valid;
            field_adv = S_PAYLOAD;
         end
         default: ;
      endcase
   end

   // Next-state decision: truncation > sequence > expected valid > timeout,
   // with ctrl_enable low overriding everything as a silent abort.
   always_comb begin
      state_nxt = state;
      err_fire  = 1'b0;
      err_sel   = ERR_NONE;
      case (state)
         S_IDLE: begin
            if (ctrl_enable && rx_active) state_nxt = S_HUNT;
         end
         S_HUNT: begin
            if (preamble_valid) begin
               state_nxt = S_DST;
            end else if (wdog == HUNT_LAST) begin
               err_fire = 1'b1;
               err_sel  = ERR_NO_SOF;
            end
         end
         S_DST, S_SRC, S_TYPE: begin
            if (!rx_active) begin
               err_fire = 1'b1;
               err_sel  = ERR_TRUNCATED;
            end else if (other_v) begin
               err_fire = 1'b1;
               err_sel  = ERR_SEQUENCE;
            end else if (exp_v) begin
               state_nxt = field_adv;
            end else if (wdog == FIELD_LAST) begin
               err_fire = 1'b1;
               err_sel  = ERR_FIELD_TMO;
            end
         end
         S_PAYLOAD: begin
            // frame_done was already issued for the last byte, so the final
            // cycle only closes the window.
            if (wdog == PAY_LAST) begin
               state_nxt = S_GAP;
            end else if (!rx_active) begin
               err_fire = 1'b1;
               err_sel  = ERR_TRUNCATED;
            end
         end
         S_GAP: begin
            if (wdog == IFG_LAST) state_nxt = (ctrl_enable && rx_active) ? S_HUNT : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase

      if (err_fire) state_nxt = S_GAP;

      if (!ctrl_enable) begin
         state_nxt = S_IDLE;
         err_fire  = 1'b0;
         err_sel   = ERR_NONE;
      end
   end

   // Watchdog restarts on every state entry; parked at zero in IDLE.
   always_comb begin
      if (state_nxt != state || state_nxt == S_IDLE) wdog_nxt = '0;
      else                                           wdog_nxt = wdog + 1'b1;
      done_fire = (state_nxt == S_PAYLOAD) && (wdog_nxt == PAY_LAST);
   end

   // State and watchdog registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         wdog  <= '0;
      end else begin
         state <= state_nxt;
         wdog  <= wdog_nxt;
      end
   end

   // Registered outputs are derived from the next state so they line up
   // with the cycle the state is actually in.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         parser_enable  <= 1'b0;
         payload_active <= 1'b0;
         payload_index  <= '0;
         frame_done     <= 1'b0;
         frame_error    <= 1'b0;
         error_code     <= ERR_NONE;
         frame_count    <= '0;
         error_count    <= '0;
      end else begin
         parser_enable  <= (state_nxt == S_HUNT) || (state_nxt == S_DST) ||
                           (state_nxt == S_SRC)  || (state_nxt == S_TYPE);
         payload_active <= (state_nxt == S_PAYLOAD);
         payload_index  <= (state_nxt == S_PAYLOAD) ? 8'(wdog_nxt) : 8'd0;
         frame_done     <= done_fire;
         frame_error    <= err_fire;
         if (err_fire) error_code <= err_sel;
         if (done_fire && frame_count != '1) frame_count <= frame_count + 1'b1;
         if (err_fire && error_count != '1) error_count <= error_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_header_sequencer.sv
// tb_header_sequencer: randomized frame scenarios with a scoreboard.
// The driver issues whole frames (good, timeout, sequence, truncation,
// abort) and pushes the predicted completion/error record; a monitor pops
// and compares on every frame_done / frame_error pulse.
module tb_header_sequencer;
   localparam int HT   = 64;
   localparam int FT   = 16;
   localparam int PL   = 46;
   localparam int IFG  = 12;
   localparam int CW   = 2;
   localparam int CMAX = (1 << CW) - 1;

   localparam int K_GOOD  = 0;
   localparam int K_TMO   = 1;
   localparam int K_SEQ   = 2;
   localparam int K_SEQTR = 3;
   localparam int K_TRUNC = 4;
   localparam int K_ABORT = 5;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          ctrl_enable = 1'b0;
   logic          rx_active = 1'b0;
   logic          preamble_valid = 1'b0;
   logic          dst_addr_valid = 1'b0;
   logic          src_addr_valid = 1'b0;
   logic          type_length_valid = 1'b0;
   logic          parser_enable;
   logic          payload_active;
   logic [7:0]    payload_index;
   logic          frame_done;
   logic          frame_error;
   logic [2:0]    error_code;
   logic [CW-1:0] frame_count;
   logic [CW-1:0] error_count;

   header_sequencer #(
      .HUNT_TIMEOUT (HT),
      .FIELD_TIMEOUT(FT),
      .PAYLOAD_LEN  (PL),
      .IFG_CYCLES   (IFG),
      .CNT_W        (CW)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .ctrl_enable      (ctrl_enable),
      .rx_active        (rx_active),
      .preamble_valid   (preamble_valid),
      .dst_addr_valid   (dst_addr_valid),
      .src_addr_valid   (src_addr_valid),
      .type_length_valid(type_length_valid),
      .parser_enable    (parser_enable),
      .payload_active   (payload_active),
      .payload_index    (payload_index),
      .frame_done       (frame_done),
      .frame_error      (frame_error),
      .error_code       (error_code),
      .frame_count      (frame_count),
      .error_count      (error_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit is_err;
      int code;
      int fc;
      int ec;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   m_fc = 0;
   int   m_ec = 0;
   int   m_code = 0;
   int   run = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // One input cycle: apply valids/rx now, advance to the next negedge.
   task automatic drive(input logic [3:0] v, input logic rx);
      {type_length_valid, src_addr_valid, dst_addr_valid, preamble_valid} = v;
      rx_active = rx;
      @(negedge clock);
   endtask

   // Reference model: outcome of a frame from its scenario description.
   function automatic int ref_code(input int kind, input int ph);
      case (kind)
         K_TMO:            return (ph == 0) ? 1 : 2;
         K_SEQ:            return 3;
         K_SEQTR, K_TRUNC: return 4;
         default:          return 0;
      endcase
   endfunction

   function automatic void predict(input int kind, input int ph);
      exp_t e;
      if (kind == K_ABORT) return;
      if (kind == K_GOOD) begin
         m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
         e.is_err = 1'b0;
      end else begin
         m_ec   = (m_ec < CMAX) ? m_ec + 1 : CMAX;
         m_code = ref_code(kind, ph);
         e.is_err = 1'b1;
      end
      e.code = m_code;
      e.fc   = m_fc;
      e.ec   = m_ec;
      sbq.push_back(e);
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pe"}, parser_enable, 0);
      chk({tag, "_pa"}, payload_active, 0);
      chk({tag, "_idx"}, payload_index, 0);
      chk({tag, "_done"}, frame_done, 0);
      chk({tag, "_err"}, frame_error, 0);
      chk({tag, "_code"}, error_code, 0);
      chk({tag, "_fc"}, frame_count, 0);
      chk({tag, "_ec"}, error_count, 0);
   endtask

   // Let any pending pulse land, return to IDLE, then compare status.
   task automatic finish_frame();
      drive(4'b0, 1'b1);
      drive(4'b0, 1'b1);
      ctrl_enable = 1'b0;
      drive(4'b0, 1'b1);
      drive(4'b0, 1'b1);
      chk("frame_count", frame_count, m_fc);
      chk("error_count", error_count, m_ec);
      chk("error_code", error_code, m_code);
      chk("scoreboard_drained", sbq.size(), 0);
   endtask

   task automatic run_frame(input int kind, input int ph, input bit fixed);
      int lim, off, w, n;
      int fixed_off[4];
      fixed_off = '{8, 5, 5, 1};
      predict(kind, ph);
      ctrl_enable = 1'b1;
      drive(4'b0, 1'b1);                       // IDLE -> HUNT decision cycle
      for (int p = 0; p < 4; p++) begin
         lim = (p == 0) ? HT : FT;
         if (fixed) off = fixed_off[p];
         else       off = ($urandom_range(0, 3) == 0) ? lim - 1 : int'($urandom_range(0, lim - 1));
         if (p == ph && kind != K_GOOD) begin
            case (kind)
               K_TMO: repeat (lim) drive(4'b0, 1'b1);
               K_SEQ, K_SEQTR: begin
                  w = $urandom_range(0, 2);
                  if (w >= p) w++;
                  repeat (off) drive(4'b0, 1'b1);
                  drive(4'(1 << w), (kind == K_SEQ));
               end
               K_TRUNC: begin
                  repeat (off) drive(4'b0, 1'b1);
                  drive(4'b0, 1'b0);
               end
               default: begin
                  repeat (off) drive(4'b0, 1'b1);
                  ctrl_enable = 1'b0;
                  drive(4'b0, 1'b1);
                  chk("abort_parser_enable", parser_enable, 0);
               end
            endcase
            finish_frame();
            return;
         end
         repeat (off) drive(4'b0, 1'b1);
         drive(4'(1 << p), 1'b1);
      end
      if (ph == 4 && kind != K_GOOD) begin
         off = $urandom_range(0, PL - 2);
         repeat (off) drive(4'b0, 1'b1);
         if (kind == K_TRUNC) begin
            drive(4'b0, 1'b0);
         end else begin
            ctrl_enable = 1'b0;
            drive(4'b0, 1'b1);
            chk("abort_payload_active", payload_active, 0);
         end
         finish_frame();
         return;
      end
      repeat (PL) drive(4'b0, 1'b1);
      n = 0;
      while (parser_enable == 1'b0 && n < IFG + 8) begin
         n++;
         drive(4'b0, 1'b1);
      end
      chk("gap_length", n, IFG);
      finish_frame();
   endtask

   // Monitor: payload index continuity and scoreboard pops on pulses.
   always @(negedge clock) begin
      if (!reset_n) begin
         run = 0;
      end else begin
         if (payload_active) begin
            run++;
            chk("payload_index", payload_index, run - 1);
         end else begin
            run = 0;
         end
         if (frame_done || frame_error) begin
            chk("done_error_exclusive", int'(frame_done && frame_error), 0);
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: done=%0d error=%0d with nothing expected (t=%0t)",
                        frame_done, frame_error, $time);
            end else begin
               mon_e = sbq.pop_front();
               chk("pulse_is_error", frame_error, mon_e.is_err);
               chk("pulse_error_code", error_code, mon_e.code);
               chk("pulse_frame_count", frame_count, mon_e.fc);
               chk("pulse_error_count", error_count, mon_e.ec);
               if (frame_done) chk("payload_run_at_done", run, PL);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete, got t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int k, ph;
      #2;
      chk_all_zero("reset");
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      chk_all_zero("post_reset");

      // Good frames first: documented timing, then saturation of frame_count.
      run_frame(K_GOOD, 0, 1'b1);
      repeat (4) run_frame(K_GOOD, 0, 1'b0);

      // Directed error and abort cases.
      run_frame(K_TMO, 0, 1'b0);
      run_frame(K_TMO, 1, 1'b0);
      run_frame(K_SEQ, 1, 1'b0);
      run_frame(K_SEQTR, 1, 1'b0);
      run_frame(K_TRUNC, 4, 1'b0);
      run_frame(K_ABORT, 3, 1'b0);

      // Randomized mix.
      for (int i = 0; i < 30; i++) begin
         k = $urandom_range(0, 5);
         case (k)
            K_GOOD:         ph = 0;
            K_TMO:          ph = $urandom_range(0, 3);
            K_SEQ, K_SEQTR: ph = $urandom_range(1, 3);
            K_TRUNC:        ph = $urandom_range(1, 4);
            default:        ph = $urandom_range(0, 4);
         endcase
         run_frame(k, ph, 1'b0);
      end

      // Reset in the middle of the payload window.
      ctrl_enable = 1'b1;
      drive(4'b0, 1'b1);
      for (int p = 0; p < 4; p++) begin
         drive(4'b0, 1'b1);
         drive(4'(1 << p), 1'b1);
      end
      repeat (10) drive(4'b0, 1'b1);
      chk("midreset_in_payload", payload_active, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(negedge clock);
      ctrl_enable = 1'b0;
      reset_n = 1'b1;
      m_fc = 0;
      m_ec = 0;
      m_code = 0;
      @(negedge clock);
      run_frame(K_GOOD, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
